// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared encodings for the unified instruction/data memory arbiter:
// FSM states, legal memory latency range and requester identifiers.
package imem_dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_WAIT_D = 2'd1,
        ARB_WAIT_I = 2'd2,
        ARB_DONE   = 2'd3
    } arb_state_e;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_D  = 1'b1
    } req_id_e;

    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 15;

    // Memory is word-organised; byte offset bits are always dropped.
    function automatic logic [31:0] word_addr(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/imem_dmem_arbiter_lat_timer.sv
// Loadable down-counter that flags the last cycle of a memory access.
// Counts down to zero and parks there; expire is high while count is 1.
module lat_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = (count_q == CNT_W'(1));

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Single-port memory arbiter between IF (fetch) and MEM (load/store).
// Data has priority; one fixed-latency transaction in flight at a time.
module imem_dmem_arbiter
    import imem_dmem_arbiter_pkg::*;
#(
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    output logic        if_stall,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic        d_stall,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata
);

    localparam int LAT_EFF = (MEM_LAT < MEM_LAT_MIN) ? MEM_LAT_MIN :
                             (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX : MEM_LAT;
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LAT_EFF);

    arb_state_e  state_q, state_d;
    logic        m_req_q, m_req_d;
    logic        m_we_q, m_we_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        if_valid_q, if_valid_d;
    logic        d_valid_q, d_valid_d;
    logic        drop_q, drop_d;
    logic        timer_load;
    logic        timer_expire;
    req_id_e     wait_id;

    // Counter is loaded in the m_req cycle, so expiry lands MEM_LAT cycles later.
    lat_timer #(.CNT_W(CNT_W)) u_lat_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (LAT_LOAD),
        .expire   (timer_expire)
    );

    always_comb begin
        state_d    = state_q;
        m_req_d    = 1'b0;
        m_we_d     = m_we_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if_valid_d = 1'b0;
        d_valid_d  = 1'b0;
        drop_d     = drop_q;
        timer_load = 1'b0;
        wait_id    = (state_q == ARB_WAIT_D) ? REQ_D : REQ_IF;

        case (state_q)
            ARB_IDLE: begin
                if (d_req) begin
                    state_d   = ARB_WAIT_D;
                    m_req_d   = 1'b1;
                    m_we_d    = d_we;
                    m_addr_d  = word_addr(d_addr);
                    m_wdata_d = d_wdata;
                end else if (if_req && !if_flush) begin
                    state_d   = ARB_WAIT_I;
                    m_req_d   = 1'b1;
                    m_we_d    = 1'b0;
                    m_addr_d  = word_addr(if_addr);
                    m_wdata_d = 32'h0;
                end
            end
            ARB_WAIT_D, ARB_WAIT_I: begin
                timer_load = m_req_q;
                if (wait_id == REQ_IF && if_flush) begin
                    drop_d = 1'b1;
                end
                if (timer_expire) begin
                    state_d = ARB_DONE;
                    if (wait_id == REQ_D) begin
                        d_valid_d = 1'b1;
                        if (!m_we_q) begin
                            d_rdata_d = m_rdata;
                        end
                    end else if (!(drop_q || if_flush)) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = m_rdata;
                    end
                end
            end
            ARB_DONE: begin
                state_d = ARB_IDLE;
                drop_d  = 1'b0;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= 32'h0;
            m_wdata_q  <= 32'h0;
            if_rdata_q <= 32'h0;
            d_rdata_q  <= 32'h0;
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            m_req_q    <= m_req_d;
            m_we_q     <= m_we_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            if_valid_q <= if_valid_d;
            d_valid_q  <= d_valid_d;
            drop_q     <= drop_d;
        end
    end

    // A redirect arriving in the completion cycle still suppresses the fetch.
    assign if_valid = if_valid_q & ~if_flush;
    assign d_valid  = d_valid_q;
    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign m_req    = m_req_q;
    assign m_we     = m_we_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign if_stall = if_req & ~if_valid;
    assign d_stall  = d_req & ~d_valid;

endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Schedules a single-port unified instruction/data memory between the pipeline's IF stage (fetch, read-only) and MEM stage (load/store driven by MemRead/MemWrite).
- Issues one transaction at a time to a fixed-latency memory.
- Returns data to the requester with a one-cycle valid pulse.
- Generates per-stage stall signals for the pipeline hazard logic.

Parameters:
- MEM_LAT, 2, memory read latency in cycles from m_req to m_rdata valid; legal 1..15.
- CNT_W, 4, width of the latency counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held until if_valid.
- if_addr  in  32  fetch byte address.
- if_flush  in  1  branch/jump redirect; discard in-flight fetch.
- if_rdata  out  32  fetched instruction.
- if_valid  out  1  one-cycle fetch completion pulse.
- if_stall  out  1  if_req & ~if_valid.
- d_req  in  1  data request (MemRead|MemWrite); held until d_valid.
- d_we  in  1  1 = store.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_rdata  out  32  load data.
- d_valid  out  1  one-cycle data completion pulse.
- d_stall  out  1  d_req & ~d_valid.
- m_req  out  1  memory strobe, one cycle per transaction.
- m_we  out  1  memory write enable.
- m_addr  out  32  word address {addr[31:2],2'b00}.
- m_wdata  out  32  write data.
- m_rdata  in  32  read data, valid MEM_LAT cycles after m_req.

Behaviour:
- States: IDLE, WAIT_D, WAIT_I, DONE.
- Reset (async): state IDLE; counter 0; drop flag 0. All outputs 0: m_req, m_we, m_addr, m_wdata, if_rdata, d_rdata, if_valid, d_valid. Any in-flight transaction is abandoned.
- IDLE: d_req has priority. On d_req go to WAIT_D; else on if_req & ~if_flush go to WAIT_I. Otherwise stay.
- Acceptance registers m_addr, m_we (= d_we for data, 0 for fetch) and m_wdata. These hold stable until leaving DONE.
- First WAIT cycle: m_req=1, counter=MEM_LAT.
- WAIT: counter decrements each cycle. At counter==1, capture m_rdata into d_rdata or if_rdata and go to DONE.
- DONE: pulse d_valid, or pulse if_valid unless drop flag is set or if_flush=1. No acceptance in DONE. Next state IDLE; drop flag clears.
- Timing: request seen in IDLE at cycle 0 → m_req cycle 1 → m_rdata sampled cycle 1+MEM_LAT → valid pulse cycle 2+MEM_LAT → next acceptance cycle 3+MEM_LAT.
- Stores: d_valid pulses on the same schedule. d_rdata is unchanged.
- if_flush during WAIT_I sets the drop flag; the memory access completes but its result is discarded.
- if_flush has no effect on data transactions; stores always complete.
- if_req/d_req deasserting mid-transaction is illegal; the transaction completes regardless.
- Stalls are combinational from the request inputs and the valid registers.
- If both requests are pending, IF waits at most one data transaction. The pipeline holds one d_req at a time, so fetch is not starved.

Decomposition:
- Shared include (ctrl_encode_def.v style): state encodings ARB_IDLE/ARB_WAIT_D/ARB_WAIT_I/ARB_DONE; MEM_LAT bounds; requester IDs REQ_IF/REQ_D.
- One sub-module: lat_timer. Loadable down-counter of CNT_W bits with async reset; outputs expire at count==1.

Test Plan:
- Load, MEM_LAT=2: d_req=1, d_we=0, d_addr=0x103 at cycle 0 → m_req=1 and m_addr=0x100 at cycle 1; memory returns 0xDEADBEEF at cycle 3 → d_valid=1 with d_rdata=0xDEADBEEF at cycle 4; d_stall=1 for cycles 0-3 and 0 at cycle 4.
- Store: d_we=1, d_addr=0x204, d_wdata=0x12345678 at cycle 0 → m_req at cycle 1; m_we=1 and m_wdata=0x12345678 stable cycles 1-4; d_valid at cycle 4.
- Contention: if_req and d_req both asserted at cycle 0 → data m_req at cycle 1, d_valid at cycle 4; fetch accepted cycle 5, m_req at cycle 6, if_valid at cycle 9.
- Flush: fetch accepted cycle 0, if_flush pulsed at cycle 2 → no if_valid at cycle 4; IDLE at cycle 5; a new if_addr=0x40 is accepted at cycle 5.
- Async reset: rst asserted mid-cycle 2 of a load → m_req, d_valid and state clear immediately without waiting for a clock edge; after release with d_req still high → re-issued, m_req one cycle after first IDLE edge.
- MEM_LAT=1 build: load at cycle 0 → m_req cycle 1, d_valid cycle 3, back-to-back next load m_req cycle 5.
